// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// Module : reset_sequencer_pkg
// Brief  : Shared state encodings and helpers for the reset sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rs_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : reset_sequencer_pkg

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module : reset_sequencer
// Brief  : Merges POR and synchronous reset requests, releases reset domains
//          in index order with a fixed gap, and keeps a sticky cause vector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int N_STAGE   = 3,
    parameter int HOLD_LEN  = 16,
    parameter int STAGE_GAP = 4
) (
    input  logic               ck,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic               cause_clr,
    output logic [N_STAGE-1:0] stage_rst,
    output logic               busy,
    output logic [N_REQ:0]     cause
);

    localparam int c_CW = $clog2(max2(HOLD_LEN, STAGE_GAP)) + 1;
    localparam int c_IW = $clog2(N_STAGE) + 1;

    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLD_LEN - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(STAGE_GAP - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(N_STAGE - 1);
    localparam logic [N_REQ:0]  c_CAUSE_POR = {1'b1, {N_REQ{1'b0}}};

    rs_state_t          r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [c_IW-1:0]    r_idx;
    logic [N_STAGE-1:0] r_stage_rst;
    logic [N_REQ:0]     r_cause;

    rs_state_t          w_state_nx;
    logic [c_CW-1:0]    w_cnt_nx;
    logic [c_IW-1:0]    w_idx_nx;
    logic [N_STAGE-1:0] w_stage_nx;
    logic               w_req_any;

    assign w_req_any = |req;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ASSERT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_stage_rst <= '1;
            r_cause     <= c_CAUSE_POR;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_stage_rst <= w_stage_nx;
            // A request landing on the clear strobe still records its cause.
            r_cause     <= (cause_clr ? '0 : r_cause) | {1'b0, req};
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_stage_nx = r_stage_rst;

        case (r_state)
            ST_ASSERT: begin
                w_stage_nx = '1;
                if (w_req_any) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_stage_nx[0] = 1'b0;
                    w_cnt_nx      = '0;
                    w_idx_nx      = c_IW'(1);
                    w_state_nx    = (N_STAGE == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    w_cnt_nx = r_cnt + c_CW'(1);
                end
            end

            ST_RELEASE: begin
                if (w_req_any) begin
                    w_state_nx = ST_ASSERT;
                    w_stage_nx = '1;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                end else if (r_cnt == c_GAP_LAST) begin
                    // Only the stage at r_idx drops, so releases stay strictly ordered.
                    for (int i = 0; i < N_STAGE; i++) begin
                        if (c_IW'(i) == r_idx) begin
                            w_stage_nx[i] = 1'b0;
                        end
                    end
                    w_cnt_nx = '0;
                    w_idx_nx = r_idx + c_IW'(1);
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nx = ST_RUN;
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_CW'(1);
                end
            end

            ST_RUN: begin
                w_stage_nx = '0;
                w_cnt_nx   = '0;
                if (w_req_any) begin
                    w_state_nx = ST_ASSERT;
                    w_stage_nx = '1;
                    w_idx_nx   = '0;
                end
            end

            default: begin
                w_state_nx = ST_ASSERT;
                w_stage_nx = '1;
                w_cnt_nx   = '0;
                w_idx_nx   = '0;
            end
        endcase
    end

    assign stage_rst = r_stage_rst;
    assign busy      = (r_state != ST_RUN);
    assign cause     = r_cause;

endmodule : reset_sequencer

`default_nettype wire
